// File: rtl/rs232_rx.sv
// rs232_rx: UART receiver, 8N1 (8E1 when RS232_RX_PARITY_EN is defined), with receive FIFO and sticky error flags
module rs232_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       rd_en,
  input  logic       err_clr,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       rx_empty,
  output logic       rx_full,
  output logic       overrun,
  output logic       frame_err,
  output logic       parity_err
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [BW-1:0] HALF = BW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] FULL = BW'(CLKS_PER_BIT - 1);
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef RS232_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    BREAK
  } state_t;
  state_t state_q, state_d;
  logic [1:0] sync_q;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic [7:0] mem_q [FIFO_DEPTH];
  logic [7:0] rd_data_q;
  logic rd_valid_q, overrun_q, frame_err_q;
  logic rx_s, tick, stop_tick, par_bad, push, pop, set_ovr, set_fe;
  assign rx_s      = sync_q[1];
  assign tick      = baud_q == '0;
  assign rx_empty  = wr_ptr_q == rd_ptr_q;
  assign rx_full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;
  // two-flop synchronizer for the asynchronous line, idling high
  always_ff @(posedge clk or posedge rst)
    if (rst) sync_q <= 2'b11;
    else sync_q <= {sync_q[0], rx};
  // frame state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  // frame sequencing: start check, 8 data bits, optional parity, stop, break hold-off
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (!rx_s) state_d = START;
      START:  if (tick) state_d = rx_s ? IDLE : DATA;
`ifdef RS232_RX_PARITY_EN
      DATA:   if (tick && bit_q == 3'd7) state_d = PARITY;
      PARITY: if (tick) state_d = STOP;
`else
      DATA:   if (tick && bit_q == 3'd7) state_d = STOP;
`endif
      STOP:   if (tick) state_d = rx_s ? IDLE : BREAK;
      BREAK:  if (rx_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // baud/bit counters, shifter and the stop-sample verdict
  always_comb begin
    baud_d    = state_q == IDLE ? HALF : tick ? FULL : baud_q - BW'(1);
    bit_d     = state_q == DATA ? bit_q + {2'b0, tick} : 3'd0;
    shift_d   = state_q == DATA && tick ? {rx_s, shift_q[7:1]} : shift_q;
    stop_tick = state_q == STOP && tick;
    pop       = rd_en && !rx_empty;
    set_fe    = stop_tick && !rx_s;
    push      = stop_tick && rx_s && !par_bad && (!rx_full || pop);
    set_ovr   = stop_tick && rx_s && !par_bad && rx_full && !pop;
  end
  // receive datapath registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      baud_q  <= HALF;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
    end else begin
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  // store the accepted byte at the tail slot
  always_ff @(posedge clk)
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= shift_q;
  // pointer updates and registered read port; a pop reads the head before any same-cycle write lands
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rd_data_q  <= 8'd0;
      rd_valid_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (pop) rd_data_q <= mem_q[rd_ptr_q[AW-1:0]];
      rd_valid_q <= pop;
    end
  // sticky flags; a new error beats a simultaneous clear
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      overrun_q   <= set_ovr | (overrun_q & ~err_clr);
      frame_err_q <= set_fe | (frame_err_q & ~err_clr);
    end
`ifdef RS232_RX_PARITY_EN
  logic par_bad_q, parity_err_q, set_pe;
  assign par_bad    = par_bad_q;
  assign parity_err = parity_err_q;
  assign set_pe     = stop_tick && rx_s && par_bad_q;
  // even-parity check captured at the parity sample, consumed at the stop sample
  always_ff @(posedge clk or posedge rst)
    if (rst) par_bad_q <= 1'b0;
    else if (state_q == PARITY && tick) par_bad_q <= rx_s ^ (^shift_q);
  // sticky parity flag; set wins over clear
  always_ff @(posedge clk or posedge rst)
    if (rst) parity_err_q <= 1'b0;
    else parity_err_q <= set_pe | (parity_err_q & ~err_clr);
`else
  assign par_bad    = 1'b0;
  assign parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_rs232_rx.sv
// tb_rs232_rx: table, directed and randomized checks of rs232_rx against a queue-based byte/flag model
module tb_rs232_rx;
  localparam int CPB = 16;
  localparam int DEPTH = 4;
`ifdef RS232_RX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int STOP_SAMPLE = PAR ? 171 : 155;
  logic clk = 1'b0, rst = 1'b1, rx = 1'b1, rd_en = 1'b0, err_clr = 1'b0;
  logic [7:0] rd_data;
  logic rd_valid, rx_empty, rx_full, overrun, frame_err, parity_err;
  int total = 0, bad = 0;
  logic [7:0] mq[$];
  bit m_ovr, m_fe, m_pe;
  logic [7:0] m_last;
  typedef struct {
    bit send;
    logic [7:0] data;
    bit stop;
    bit pflip;
    int reads;
    bit clr;
    bit e_empty, e_full, e_ovr, e_fe, e_pe;
  } vec_t;
  vec_t vecs[$];

  rs232_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .rx(rx), .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
    .rx_empty(rx_empty), .rx_full(rx_full), .overrun(overrun), .frame_err(frame_err),
    .parity_err(parity_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string n, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", n, got, exp);
    end
  endtask

  task automatic chk_flags(input string p, input bit e_empty, input bit e_full, input bit e_ovr, input bit e_fe, input bit e_pe);
    chk($sformatf("%s_empty", p), 8'(rx_empty), 8'(e_empty));
    chk($sformatf("%s_full", p), 8'(rx_full), 8'(e_full));
    chk($sformatf("%s_overrun", p), 8'(overrun), 8'(e_ovr));
    chk($sformatf("%s_frame_err", p), 8'(frame_err), 8'(e_fe));
    chk($sformatf("%s_parity_err", p), 8'(parity_err), 8'(e_pe));
  endtask

  task automatic model_frame(input logic [7:0] d, input bit stop, input bit pflip);
    if (!stop) m_fe = 1'b1;
    else if (PAR && pflip) m_pe = 1'b1;
    else if (mq.size() == DEPTH) m_ovr = 1'b1;
    else mq.push_back(d);
  endtask

  task automatic model_read(output logic ev, output logic [7:0] ed);
    ev = 1'b0;
    if (mq.size() > 0) begin
      ev = 1'b1;
      m_last = mq.pop_front();
    end
    ed = m_last;
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovr = 1'b0;
    m_fe = 1'b0;
    m_pe = 1'b0;
    m_last = 8'h00;
  endtask

  // drives one frame; optionally strobes rd_en so the read lands on edge rd_at (counted from the start bit)
  task automatic send_frame(input logic [7:0] d, input bit stop, input bit pflip, input int rd_at,
                            output logic gv, output logic [7:0] gd);
    logic [10:0] bits;
    int nb;
    int c;
    c = 0;
    nb = PAR ? 11 : 10;
    bits = PAR ? {stop, (^d) ^ pflip, d, 1'b0} : {1'b0, stop, d, 1'b0};
    gv = 1'b0;
    gd = 8'h00;
    for (int b = 0; b < nb; b++) begin
      rx = bits[b];
      for (int k = 0; k < CPB; k++) begin
        tick();
        c++;
        if (c == rd_at - 1) rd_en = 1'b1;
        if (c == rd_at) begin
          rd_en = 1'b0;
          gv = rd_valid;
          gd = rd_data;
        end
      end
    end
  endtask

  task automatic step(input bit send, input logic [7:0] d, input bit stop, input bit pflip, input int reads, input bit clr);
    logic ev, gv;
    logic [7:0] ed, gd;
    if (send) begin
      send_frame(d, stop, pflip, -10, gv, gd);
      if (!stop) begin
        rx = 1'b0;
        repeat (40) tick();
      end
      rx = 1'b1;
      repeat (4) tick();
      model_frame(d, stop, pflip);
    end
    if (reads > 0) begin
      rd_en = 1'b1;
      for (int k = 0; k < reads; k++) begin
        tick();
        model_read(ev, ed);
        chk("rd_valid", 8'(rd_valid), 8'(ev));
        chk("rd_data", rd_data, ed);
      end
      rd_en = 1'b0;
      tick();
      chk("rd_valid_pulse", 8'(rd_valid), 8'h00);
    end
    if (clr) begin
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      tick();
      m_ovr = 1'b0;
      m_fe = 1'b0;
      m_pe = 1'b0;
    end
  endtask

  initial begin
    logic gv, ev;
    logic [7:0] gd, ed, d;
    bit st, pf, cl;
    int nr;
    vecs.push_back('{1'b1, 8'h55, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 8'hA3, 1'b1, 1'b0, 2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 8'h01, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 8'h02, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 8'h03, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 8'h04, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 8'h05, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 4, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 8'h3C, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 8'h7E, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
`ifdef RS232_RX_PARITY_EN
    vecs.push_back('{1'b1, 8'h07, 1'b1, 1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{1'b1, 8'h07, 1'b1, 1'b0, 1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
`endif
    model_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("reset_rd_data", rd_data, 8'h00);
    chk("reset_rd_valid", 8'(rd_valid), 8'h00);
    chk_flags("reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    foreach (vecs[i]) begin
      step(vecs[i].send, vecs[i].data, vecs[i].stop, vecs[i].pflip, vecs[i].reads, vecs[i].clr);
      chk_flags($sformatf("vec%0d", i), vecs[i].e_empty, vecs[i].e_full, vecs[i].e_ovr, vecs[i].e_fe, vecs[i].e_pe);
    end
    step(1'b1, 8'h11, 1'b1, 1'b0, 0, 1'b0);
    step(1'b1, 8'h22, 1'b1, 1'b0, 0, 1'b0);
    step(1'b1, 8'h33, 1'b1, 1'b0, 0, 1'b0);
    step(1'b1, 8'h44, 1'b1, 1'b0, 0, 1'b0);
    send_frame(8'h99, 1'b1, 1'b0, STOP_SAMPLE, gv, gd);
    rx = 1'b1;
    repeat (4) tick();
    model_read(ev, ed);
    mq.push_back(8'h99);
    chk("full_pushpop_valid", 8'(gv), 8'(ev));
    chk("full_pushpop_data", gd, ed);
    chk_flags("full_pushpop", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 4, 1'b0);
    chk("drain_empty", 8'(rx_empty), 8'h01);
    send_frame(8'hC6, 1'b1, 1'b0, STOP_SAMPLE, gv, gd);
    rx = 1'b1;
    repeat (4) tick();
    model_read(ev, ed);
    mq.push_back(8'hC6);
    chk("empty_pushread_valid", 8'(gv), 8'(ev));
    chk("empty_pushread_data", gd, ed);
    chk_flags("empty_pushread", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b0);
    rx = 1'b0;
    repeat (5) tick();
    rx = 1'b1;
    repeat (40) tick();
    chk_flags("glitch", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      d = 8'($urandom);
      st = $urandom_range(0, 7) != 0;
      pf = PAR && st && mq.size() < DEPTH && $urandom_range(0, 4) == 0;
      nr = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 3)) : 0;
      cl = $urandom_range(0, 7) == 0;
      step(1'b1, d, st, pf, nr, cl);
      chk_flags($sformatf("rnd%0d", i), mq.size() == 0, mq.size() == DEPTH, m_ovr, m_fe, m_pe);
    end
    step(1'b1, 8'h5A, 1'b1, 1'b0, 0, 1'b0);
    rx = 1'b0;
    repeat (24) tick();
    rx = 1'b1;
    repeat (30) tick();
    rx = 1'b0;
    repeat (20) tick();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    rx = 1'b1;
    repeat (200) tick();
    model_reset();
    chk_flags("mid_reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("mid_reset_rd_data", rd_data, 8'h00);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
